// File: rtl/vpu_pkg.sv
// Shared opcode definitions for the vector ALU pipeline.
package vpu_pkg;

  localparam int VPU_OP_W = 4;

  typedef enum logic [VPU_OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_MAX  = 4'd3,
    OP_MIN  = 4'd4,
    OP_RELU = 4'd5,
    OP_PASS = 4'd6
  } vpu_op_e;

  localparam int VPU_NUM_OPS = 7;

endpackage

// File: rtl/vpu_lane_alu.sv
// Single-lane combinational ALU. Define VPU_SAT_EN to saturate signed
// ADD/SUB overflow instead of wrapping.
module vpu_lane_alu
  import vpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   opcode,
  input  logic              lane_en,
  output logic [DATA_W-1:0] res,
  output logic              ovf,
  output logic              err
);

  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] sum, diff, prod, val;
  logic              add_ovf, sub_ovf, ovf_raw;

  // NOTE: every output and temporary gets a default before the case so no latch is inferred.
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    prod    = a * b;
    add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
    val     = '0;
    ovf_raw = 1'b0;
    err     = 1'b0;
    case (opcode)
      OP_W'(OP_ADD):  begin val = sum;  ovf_raw = add_ovf; end
      OP_W'(OP_SUB):  begin val = diff; ovf_raw = sub_ovf; end
      OP_W'(OP_MUL):  val = prod;
      OP_W'(OP_MAX):  val = ($signed(a) > $signed(b)) ? a : b;
      OP_W'(OP_MIN):  val = ($signed(a) < $signed(b)) ? a : b;
      OP_W'(OP_RELU): val = a[DATA_W-1] ? '0 : a;
      OP_W'(OP_PASS): val = a;
      default:        err = 1'b1;
    endcase
`ifdef VPU_SAT_EN
    // Signed overflow always runs in the direction of operand a's sign.
    if (ovf_raw) val = a[DATA_W-1] ? SMIN : SMAX;
`endif
    res = lane_en ? val : '0;
    ovf = lane_en & ovf_raw;
  end

endmodule

// File: rtl/vpu_alu_pipe.sv
// Two-stage valid/ready vector ALU: S1 holds operands, S2 holds results.
// Optional saturation of ADD/SUB via macro VPU_SAT_EN (see vpu_lane_alu).
module vpu_alu_pipe
  import vpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int LANES  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         opcode,
  input  logic [LANES-1:0]        lane_en,
  input  logic [LANES*DATA_W-1:0] operand0,
  input  logic [LANES*DATA_W-1:0] operand1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] result,
  output logic                    op_err,
  output logic [LANES-1:0]        ovf
);

  logic                    s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]         s1_op_q, s1_op_d;
  logic [LANES-1:0]        s1_en_q, s1_en_d;
  logic [LANES*DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [LANES*DATA_W-1:0] s2_res_q, s2_res_d;
  logic                    s2_err_q, s2_err_d;
  logic [LANES-1:0]        s2_ovf_q, s2_ovf_d;
  logic [LANES-1:0]        ovf_q, ovf_d;

  logic [LANES*DATA_W-1:0] lane_res;
  logic [LANES-1:0]        lane_ovf, lane_err;
  logic                    s2_adv, s1_adv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vpu_lane_alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
      .a       (s1_a_q[i*DATA_W +: DATA_W]),
      .b       (s1_b_q[i*DATA_W +: DATA_W]),
      .opcode  (s1_op_q),
      .lane_en (s1_en_q[i]),
      .res     (lane_res[i*DATA_W +: DATA_W]),
      .ovf     (lane_ovf[i]),
      .err     (lane_err[i])
    );
  end

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  // Gating with rst_n keeps in_ready low throughout reset while S1 looks empty.
  assign in_ready = rst_n && s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_en_d    = s1_en_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_err_d   = s2_err_q;
    s2_ovf_d   = s2_ovf_q;
    ovf_d      = ovf_q | ({LANES{s2_valid_q && out_ready}} & s2_ovf_q);

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = opcode;
        s1_en_d = lane_en;
        s1_a_d  = operand0;
        s1_b_d  = operand1;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      s2_err_d   = s1_valid_q && (|lane_err);
      if (s1_valid_q) begin
        s2_res_d = lane_res;
        s2_ovf_d = lane_ovf;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_en_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_err_q   <= 1'b0;
      s2_ovf_q   <= '0;
      ovf_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_en_q    <= s1_en_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_err_q   <= s2_err_d;
      s2_ovf_q   <= s2_ovf_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_res_q;
  assign op_err    = s2_err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_vpu_alu_pipe.sv
// Self-checking bench for vpu_alu_pipe: directed cases plus random traffic
// scored against an arithmetic reference model and an in-order queue.
module tb_vpu_alu_pipe;
  import vpu_pkg::*;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int LANES  = 4;
  localparam int W      = LANES * DATA_W;
  localparam longint SMAXV = (longint'(1) << (DATA_W - 1)) - 1;
  localparam longint SMINV = -(longint'(1) << (DATA_W - 1));

  typedef struct {
    logic [W-1:0]     res;
    logic             err;
    logic [LANES-1:0] ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  opcode;
  logic [LANES-1:0] lane_en;
  logic [W-1:0]     operand0, operand1;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic             op_err;
  logic [LANES-1:0] ovf;

  vpu_alu_pipe #(.DATA_W(DATA_W), .OP_W(OP_W), .LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .lane_en   (lane_en),
    .operand0  (operand0),
    .operand1  (operand1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .op_err    (op_err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_fail   = 0;
  exp_t             exp_q[$];
  logic [LANES-1:0] exp_ovf = '0;
  logic             stall_pending = 1'b0;
  logic [W-1:0]     held_res;
  logic             held_err;
  logic             cyc_ov, cyc_ir, cyc_err;
  logic [W-1:0]     cyc_res;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: signed lane arithmetic in 64-bit integers, then truncated.
  function automatic exp_t model(input logic [OP_W-1:0] op, input logic [LANES-1:0] en,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, r;
    bit     ov;
    e.res = '0;
    e.ovf = '0;
    e.err = (op > 4'd6);
    for (int i = 0; i < LANES; i++) begin
      sa = longint'($signed(a[i*DATA_W +: DATA_W]));
      sb = longint'($signed(b[i*DATA_W +: DATA_W]));
      ov = 1'b0;
      case (op)
        4'd0:    r = sa + sb;
        4'd1:    r = sa - sb;
        4'd2:    r = sa * sb;
        4'd3:    r = (sa > sb) ? sa : sb;
        4'd4:    r = (sa < sb) ? sa : sb;
        4'd5:    r = (sa < 0) ? 0 : sa;
        4'd6:    r = sa;
        default: r = 0;
      endcase
      if (op <= 4'd1 && (r > SMAXV || r < SMINV)) begin
        ov = 1'b1;
`ifdef VPU_SAT_EN
        r = (r > SMAXV) ? SMAXV : SMINV;
`endif
      end
      if (en[i]) begin
        e.res[i*DATA_W +: DATA_W] = r[DATA_W-1:0];
        e.ovf[i] = ov;
      end
    end
    return e;
  endfunction

  function automatic logic [DATA_W-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return DATA_W'($urandom_range(0, 20));
      default: return DATA_W'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = rand_word();
    return v;
  endfunction

  // One clock cycle: drive at the falling edge, observe handshakes, score transfers.
  task automatic step(input logic iv, input logic [OP_W-1:0] op, input logic [LANES-1:0] en,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy,
                      output logic acc);
    exp_t e;
    @(negedge clk);
    check("ovf_sticky", W'(ovf), W'(exp_ovf));
    if (stall_pending) begin
      check("stall_valid", W'(out_valid), W'(1));
      check("stall_result", result, held_res);
      check("stall_err", W'(op_err), W'(held_err));
    end
    in_valid  = iv;
    opcode    = op;
    lane_en   = en;
    operand0  = a;
    operand1  = b;
    out_ready = ordy;
    #1;
    cyc_ov  = out_valid;
    cyc_ir  = in_ready;
    cyc_res = result;
    cyc_err = op_err;
    acc     = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", W'(out_valid), W'(0));
      end else begin
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("op_err", W'(op_err), W'(e.err));
        exp_ovf = exp_ovf | e.ovf;
      end
    end
    if (acc) exp_q.push_back(model(op, en, a, b));
    stall_pending = out_valid && !out_ready;
    held_res      = result;
    held_err      = op_err;
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, '0, '0, '0, '0, ordy, acc);
  endtask

  // Single beat with no backpressure; leaves cyc_* holding the emitted beat.
  task automatic single(input string tag, input logic [OP_W-1:0] op, input logic [LANES-1:0] en,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic acc;
    step(1'b1, op, en, a, b, 1'b1, acc);
    check({tag, "_accept"}, W'(acc), W'(1));
    idle(1'b1);
    check({tag, "_lat1"}, W'(cyc_ov), W'(0));
    idle(1'b1);
    check({tag, "_lat2"}, W'(cyc_ov), W'(1));
  endtask

  logic [OP_W-1:0] b2b_op[8];
  logic [W-1:0]    b2b_a[8], b2b_b[8];

  initial begin
    logic acc;
    logic saw_block;
    int   k;
    logic [DATA_W-1:0] exp_lane1;

    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; lane_en = '0;
    operand0 = '0; operand1 = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_result", result, '0);
    check("rst_op_err", W'(op_err), W'(0));
    check("rst_ovf", W'(ovf), W'(0));
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", W'(in_ready), W'(1));

    // ADD with signed overflow in lane 1.
    single("add", OP_ADD, 4'hF, {32'd0, 32'd0, 32'h7FFF_FFFF, 32'd7}, {32'd0, 32'd0, 32'd1, 32'd5});
`ifdef VPU_SAT_EN
    exp_lane1 = 32'h7FFF_FFFF;
`else
    exp_lane1 = 32'h8000_0000;
`endif
    check("add_lane0", W'(cyc_res[31:0]), W'(32'd12));
    check("add_lane1", W'(cyc_res[63:32]), W'(exp_lane1));
    idle(1'b1);
    check("add_ovf1", W'(ovf[1]), W'(1));

    single("max", OP_MAX, 4'hF, {4{32'hFFFF_FFFD}}, {4{32'd2}});
    check("max_lane0", W'(cyc_res[31:0]), W'(32'd2));
    single("min", OP_MIN, 4'hF, {4{32'hFFFF_FFFD}}, {4{32'd2}});
    check("min_lane0", W'(cyc_res[31:0]), W'(32'hFFFF_FFFD));
    single("relu", OP_RELU, 4'hF, {4{32'hFFFF_FFFD}}, {4{32'd2}});
    check("relu_lane0", W'(cyc_res[31:0]), W'(32'd0));

    single("mul_en", OP_MUL, 4'b0101, {4{32'd3}}, {4{32'd4}});
    check("mul_en_res", cyc_res, {32'd0, 32'd12, 32'd0, 32'd12});

    // Undefined opcode followed immediately by a valid beat.
    step(1'b1, 4'd9, 4'hF, rand_vec(), rand_vec(), 1'b1, acc);
    step(1'b1, OP_PASS, 4'hF, rand_vec(), rand_vec(), 1'b1, acc);
    idle(1'b1);
    check("bad_op_err", W'(cyc_err), W'(1));
    check("bad_op_res", cyc_res, '0);
    idle(1'b1);
    check("next_op_err", W'(cyc_err), W'(0));
    idle(1'b1);

    // Eight back-to-back beats with a three-cycle downstream stall.
    for (int i = 0; i < 8; i++) begin
      b2b_op[i] = OP_W'($urandom_range(0, 6));
      b2b_a[i]  = rand_vec();
      b2b_b[i]  = rand_vec();
    end
    k = 0;
    saw_block = 1'b0;
    for (int c = 0; c < 40 && (k < 8 || exp_q.size() > 0); c++) begin
      if (k < 8) step(1'b1, b2b_op[k], 4'hF, b2b_a[k], b2b_b[k], !(c >= 3 && c <= 5), acc);
      else       step(1'b0, '0, '0, '0, '0, 1'b1, acc);
      if (acc) k++;
      if (!cyc_ir) saw_block = 1'b1;
    end
    check("b2b_accepted", W'(k), W'(8));
    check("b2b_drained", W'(exp_q.size()), W'(0));
    check("b2b_backpressure", W'(saw_block), W'(1));

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0) ? OP_W'($urandom_range(7, 15)) : OP_W'($urandom_range(0, 6)),
           LANES'($urandom), rand_vec(), rand_vec(), 1'($urandom_range(0, 3) != 0), acc);
    end
    for (int n = 0; n < 50 && exp_q.size() > 0; n++) idle(1'b1);
    check("rand_drained", W'(exp_q.size()), W'(0));

    // Reset with two beats in flight and sticky ovf already set.
    single("ovf_setup", OP_SUB, 4'hF, {4{32'h8000_0000}}, {4{32'd1}});
    idle(1'b1);
    step(1'b1, OP_ADD, 4'hF, rand_vec(), rand_vec(), 1'b0, acc);
    step(1'b1, OP_SUB, 4'hF, rand_vec(), rand_vec(), 1'b0, acc);
    check("pre_rst_ovf_set", W'(ovf != '0), W'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_ovf", W'(ovf), W'(0));
    check("midrst_in_ready", W'(in_ready), W'(0));
    exp_q.delete();
    exp_ovf = '0;
    stall_pending = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_release_ready", W'(in_ready), W'(1));
    for (int n = 0; n < 4; n++) begin
      idle(1'b1);
      check("no_stale_beat", W'(cyc_ov), W'(0));
    end
    single("post_rst", OP_PASS, 4'hF, rand_vec(), rand_vec());
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vpu_alu_pipe.md
VPU_ALU_PIPE -- requirements
Module: vpu_alu_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning lane element width in bits (two's complement).
REQ-002 SHALL have parameter OP_W, default 4, meaning opcode width.
REQ-003 SHALL have parameter LANES, default 4, meaning number of parallel lanes.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  input beat valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port opcode  input  OP_W  operation, shared by all lanes.
REQ-009 SHALL have port lane_en  input  LANES  per-lane enable.
REQ-010 SHALL have port operand0  input  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port operand1  input  LANES*DATA_W  same packing as operand0.
REQ-012 SHALL have port out_valid  output  1  result beat valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts a result.
REQ-014 SHALL have port result  output  LANES*DATA_W  per-lane results.
REQ-015 SHALL have port op_err  output  1  current result beat carried an undefined opcode.
REQ-016 SHALL have port ovf  output  LANES  per-lane sticky overflow flags.

Function
REQ-017 SHALL transfer an input beat when in_valid && in_ready, and an output beat when out_valid && out_ready.
REQ-018 SHALL be a 2-stage pipeline: S1 registers operands/opcode/lane_en; S2 registers result; latency = 2 cycles from accept to out_valid with no backpressure.
REQ-019 SHALL advance S2 when !out_valid || out_ready, advance S1 when S1 empty or S2 advances, and drive in_ready = S1 advance condition (combinational from out_ready).
REQ-020 SHALL sustain one beat per cycle while out_ready = 1.
REQ-021 SHALL hold result, out_valid and op_err stable while out_valid && !out_ready.
REQ-022 SHALL implement opcodes: 0 ADD, 1 SUB, 2 MUL (low DATA_W bits of product), 3 MAX (signed), 4 MIN (signed), 5 RELU (operand0 < 0 ? 0 : operand0), 6 PASS (operand0).
REQ-023 SHALL produce 0 in all lanes and set op_err = 1 for that beat on opcodes 7..2^OP_W-1.
REQ-024 SHALL output 0 in any lane whose lane_en bit was 0 at acceptance, regardless of opcode.
REQ-025 SHALL compute ADD/SUB wrap-around modulo 2^DATA_W unless the VPU_SAT_EN feature is compiled in.
REQ-026 SHALL set ovf[i] when ADD/SUB signed overflow occurs in enabled lane i on an output transfer; ovf bits SHALL clear only on reset.
REQ-027 SHALL not drop or duplicate beats under any in_valid/out_ready pattern, including simultaneous accept and emit.

Reset
REQ-028 SHALL, while rst_n = 0, clear S1/S2 valid, result = 0, out_valid = 0, op_err = 0, ovf = 0, and drive in_ready = 0.
REQ-029 SHALL discard in-flight beats on reset mid-operation; in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-030 SHALL, when macro VPU_SAT_EN is defined, clamp signed ADD/SUB overflow to 2^(DATA_W-1)-1 or -2^(DATA_W-1) (ovf still set); without it, wrap per REQ-025. Other opcodes unaffected.

Structure
REQ-031 SHALL take opcode constants (vpu_op_e enum, OP_W-wide) and VPU_NUM_OPS from shared package vpu_pkg.
REQ-032 SHALL instantiate per-lane combinational sub-module vpu_lane_alu (operands, opcode, lane_en -> result, ovf, err) LANES times via generate.

Verification
REQ-033 SHALL cover: ADD, lane0 7+5, lane1 0x7FFFFFFF+1 -> out 2 cycles later, 12 and 0x80000000 (0x7FFFFFFF with VPU_SAT_EN), ovf[1]=1.
REQ-034 SHALL cover: MAX/MIN/RELU on -3 vs 2 -> MAX 2, MIN -3, RELU(-3) 0.
REQ-035 SHALL cover: opcode 9 -> result 0 all lanes, op_err=1 for that beat only.
REQ-036 SHALL cover: 8 back-to-back beats, out_ready low cycles 3-5 -> in_ready=0 when both stages full, all 8 results in order, result stable during stall.
REQ-037 SHALL cover: lane_en=4'b0101, MUL 3*4 all lanes -> lanes 0,2 = 12, lanes 1,3 = 0.
REQ-038 SHALL cover: rst_n low with 2 beats in flight -> out_valid=0, ovf=0 immediately; no stale beat after release.
